// File: rtl/gamma_sequencer.sv
// Gamma-cycle scheduler: gamma clock, gamma reset pulse, time step and phase enables.
// Define STDP_PHASE_EN to add the STDP update window after each compute window.
module gamma_sequencer #(
    parameter int GAMMA_LEN  = 16,
    parameter int UPDATE_LEN = 2,
    parameter int CNT_W      = 16,
    parameter int TIME_W     = $clog2(GAMMA_LEN)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_gammas,
    input  logic              abort,
    output logic              busy,
    output logic              gamma_clk,
    output logic              gamma_rst,
    output logic              compute_en,
    output logic              stdp_en,
    output logic [TIME_W-1:0] time_step,
    output logic [CNT_W-1:0]  gamma_idx,
    output logic              done
);

    localparam int TMAX   = (GAMMA_LEN > UPDATE_LEN) ? GAMMA_LEN : UPDATE_LEN;
    localparam int TCNT_W = $clog2(TMAX);
    localparam logic [TCNT_W-1:0] GL_LAST = TCNT_W'(GAMMA_LEN - 1);
    localparam logic [TCNT_W-1:0] GL_HALF = TCNT_W'(GAMMA_LEN / 2);
`ifdef STDP_PHASE_EN
    localparam logic [TCNT_W-1:0] UL_LAST = TCNT_W'(UPDATE_LEN - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RST,
        S_COMPUTE
`ifdef STDP_PHASE_EN
        , S_UPDATE
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_d;
    logic                gamma_end;
    logic [TIME_W-1:0]   ts_d;
    logic                gclk_d;

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        gamma_end = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_gammas != '0) begin
                        cnt_d   = num_gammas;
                        idx_d   = '0;
                        state_d = S_RST;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RST: begin
                state_d = S_COMPUTE;
                tcnt_d  = '0;
            end
            S_COMPUTE: begin
                if (tcnt_q == GL_LAST) begin
`ifdef STDP_PHASE_EN
                    state_d = S_UPDATE;
                    tcnt_d  = '0;
`else
                    gamma_end = 1'b1;
`endif
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
`ifdef STDP_PHASE_EN
            S_UPDATE: begin
                if (tcnt_q == UL_LAST) begin
                    gamma_end = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Back-to-back gammas go straight to RST so there is no idle gap.
        if (gamma_end) begin
            if (idx_q < cnt_q - CNT_W'(1)) begin
                idx_d   = idx_q + CNT_W'(1);
                state_d = S_RST;
            end else begin
                idx_d   = '0;
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end

        if (abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
            tcnt_d  = '0;
            done_d  = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        ts_d   = '0;
        gclk_d = 1'b0;
        case (state_d)
            S_RST:     gclk_d = 1'b1;
            S_COMPUTE: begin
                ts_d   = TIME_W'(tcnt_d);
                gclk_d = (tcnt_d < GL_HALF);
            end
`ifdef STDP_PHASE_EN
            S_UPDATE:  ts_d = TIME_W'(GAMMA_LEN - 1);
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            tcnt_q     <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            busy       <= 1'b0;
            gamma_clk  <= 1'b0;
            gamma_rst  <= 1'b0;
            compute_en <= 1'b0;
            time_step  <= '0;
            gamma_idx  <= '0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            busy       <= (state_d != S_IDLE);
            gamma_clk  <= gclk_d;
            gamma_rst  <= (state_d == S_RST);
            compute_en <= (state_d == S_COMPUTE);
            time_step  <= ts_d;
            gamma_idx  <= idx_d;
            done       <= done_d;
        end
    end

`ifdef STDP_PHASE_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stdp_en <= 1'b0;
        end else begin
            stdp_en <= (state_d == S_UPDATE);
        end
    end
`else
    assign stdp_en = 1'b0;
`endif

endmodule

// File: tb/tb_gamma_sequencer.sv
// Scoreboard bench for gamma_sequencer: expected per-cycle output vectors are queued at stimulus time.
module tb_gamma_sequencer;

    localparam int GL = 16;
    localparam int UL = 2;
    localparam int CW = 16;
    localparam int TW = $clog2(GL);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] num_gammas = '0;
    logic          busy, gamma_clk, gamma_rst, compute_en, stdp_en, done;
    logic [TW-1:0] time_step;
    logic [CW-1:0] gamma_idx;

    typedef struct packed {
        logic          busy;
        logic          gclk;
        logic          grst;
        logic          cen;
        logic          sen;
        logic [TW-1:0] ts;
        logic [CW-1:0] idx;
        logic          done;
    } vec_t;

    vec_t q[$];
    int   checks = 0;
    int   errors = 0;

    gamma_sequencer #(
        .GAMMA_LEN (GL),
        .UPDATE_LEN(UL),
        .CNT_W     (CW),
        .TIME_W    (TW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .num_gammas(num_gammas),
        .abort     (abort),
        .busy      (busy),
        .gamma_clk (gamma_clk),
        .gamma_rst (gamma_rst),
        .compute_en(compute_en),
        .stdp_en   (stdp_en),
        .time_step (time_step),
        .gamma_idx (gamma_idx),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic b, input logic gc, input logic gr, input logic ce,
                                input logic se, input int ts, input int idx, input logic d);
        vec_t v;
        v.busy = b;  v.gclk = gc; v.grst = gr; v.cen = ce; v.sen = se;
        v.ts = TW'(ts); v.idx = CW'(idx); v.done = d;
        return v;
    endfunction

    // Whole run expressed as cycle-by-cycle expectations, then the done cycle.
    function automatic void push_run(input int n);
        for (int g = 0; g < n; g++) begin
            q.push_back(mk(1, 1, 1, 0, 0, 0, g, 0));
            for (int t = 0; t < GL; t++)
                q.push_back(mk(1, t < GL / 2, 0, 1, 0, t, g, 0));
`ifdef STDP_PHASE_EN
            for (int u = 0; u < UL; u++)
                q.push_back(mk(1, 0, 0, 0, 1, GL - 1, g, 0));
`endif
        end
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    endfunction

    function automatic logic model_idle();
        return (q.size() == 0) || (q.size() == 1 && !q[0].busy);
    endfunction

    task automatic step(input logic s, input int n, input logic a);
        start = s;
        abort = a;
        num_gammas = CW'(n);
        if (a) begin
            while (q.size() > 1) void'(q.pop_back());
        end else if (s && model_idle()) begin
            if (q.size() == 0) q.push_back('0);
            push_run(n);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 1'b0);
    endtask

    // what: 0 = done displayed, 1 = gamma 1 at time_step 5 of compute
    task automatic wait_for(input int what, input int limit);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < limit; i++) begin
            hit = (what == 0) ? done : (compute_en && gamma_idx == CW'(1) && time_step == TW'(5));
            if (hit) break;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_timeout event=%0d not seen within %0d cycles", what, limit);
        end
    endtask

    initial begin
        vec_t act, exp;
        forever begin
            @(negedge clk or negedge rstn);
            if (!rstn) begin
                #1;
                act = {busy, gamma_clk, gamma_rst, compute_en, stdp_en, time_step, gamma_idx, done};
                checks++;
                if (act != '0) begin
                    errors++;
                    $display("FAIL reset_zero t=%0t got=%h required=0", $time, act);
                end
                q.delete();
            end else begin
                exp = (q.size() != 0) ? q.pop_front() : vec_t'('0);
                act = {busy, gamma_clk, gamma_rst, compute_en, stdp_en, time_step, gamma_idx, done};
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL cycle_trace t=%0t got=%h required=%h", $time, act, exp);
                end
            end
        end
    end

    initial begin
        int r;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(20);

        step(1, 3, 0);
        wait_for(0, 200);
        idle(3);

        step(1, 0, 0);
        idle(3);

        step(1, 3, 0);
        wait_for(1, 200);
        step(0, 0, 1);
        idle(3);
        step(1, 1, 0);
        wait_for(0, 100);
        idle(2);

        step(1, 2, 0);
        idle(5);
        step(1, 3, 0);
        wait_for(0, 200);
        step(1, 1, 0);
        wait_for(0, 100);
        idle(2);

        step(1, 2, 1);
        idle(3);

        step(1, 2, 0);
        idle(8);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(3);

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      step(1, $urandom_range(0, 3), 0);
            else if (r == 6) step(0, 0, 1);
            else if (r == 7) step(1, $urandom_range(1, 2), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 40));
        end

        for (int i = 0; i < 300 && q.size() != 0; i++) idle(1);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending required=0", q.size());
        end
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gamma_sequencer.md
# gamma_sequencer

Gamma-cycle scheduler for the temporal neuron datapath, running on the unit clock. It generates the gamma clock, a 1-cycle gamma reset pulse at each gamma rising edge, a per-gamma time-step counter, and compute/STDP-update phase enables. It runs a programmed number of gamma cycles per start request, then signals completion. It sits above the column/neuron instances and replaces ad-hoc gamma clock plus edge-detect generation with one registered source.

## Interface
- GAMMA_LEN, 16: unit-clock cycles in the compute window of one gamma cycle; legal range ≥4, even.
- UPDATE_LEN, 2: unit-clock cycles in the STDP update window; legal range ≥1, used only with STDP_PHASE_EN.
- CNT_W, 16: width of the gamma-count and gamma-index fields.
- TIME_W, $clog2(GAMMA_LEN): width of time_step.

- clk  in  1  unit clock; all state updates on posedge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  run request; sampled only in IDLE.
- num_gammas  in  CNT_W  gamma cycles to run; latched when start is accepted.
- abort  in  1  synchronous stop; overrides everything except rstn.
- busy  out  1  high from RST of the first gamma through the final cycle of the last gamma.
- gamma_clk  out  1  gamma clock.
- gamma_rst  out  1  1-cycle pulse coincident with each gamma_clk rising edge.
- compute_en  out  1  high during the compute window.
- stdp_en  out  1  high during the update window.
- time_step  out  TIME_W  unit-time index within the compute window.
- gamma_idx  out  CNT_W  index of the current gamma cycle, 0-based.
- done  out  1  1-cycle completion pulse.

## Operation
- States: IDLE, RST, COMPUTE, UPDATE. All outputs are registered.
- IDLE: all outputs 0.
  - start=1 with num_gammas≠0: latch the count, go to RST.
  - start=1 with num_gammas=0: pulse done next cycle, stay in IDLE.
- RST: lasts 1 cycle.
  - gamma_rst=1, gamma_clk=1, time_step=0, busy=1.
  - Next state is COMPUTE.
- COMPUTE: lasts GAMMA_LEN cycles.
  - compute_en=1.
  - time_step counts 0…GAMMA_LEN-1 and resets to 0 on each entry.
  - gamma_clk=1 while time_step<GAMMA_LEN/2, else 0.
  - After time_step=GAMMA_LEN-1, go to UPDATE (macro defined). Otherwise go to the end-of-gamma decision.
- UPDATE: lasts UPDATE_LEN cycles.
  - stdp_en=1, gamma_clk=0, time_step holds GAMMA_LEN-1.
  - At the end, go to the end-of-gamma decision.
- End-of-gamma decision:
  - If gamma_idx<latched count−1: increment gamma_idx and go to RST.
  - Otherwise go to IDLE with done=1 for exactly that first IDLE cycle. busy=0 and gamma_idx=0 in the same cycle.
- start while busy: ignored; the latched count is unaffected.
- abort=1 in any state: next cycle is IDLE with all outputs 0. No done pulse.
- abort and start in the same IDLE cycle: abort wins and the run does not start.
- rstn low at any time: immediate return to IDLE.
  - All outputs 0, including done.
  - Latched count and gamma_idx cleared.
- gamma_idx wraps never: the count is bounded by the latched num_gammas ≤ 2^CNT_W−1.

## Timing
- Reset values of all outputs are 0.
- start accepted at edge N gives gamma_rst=1 and gamma_clk rising in cycle N+1.
- First compute_en=1 with time_step=0 in cycle N+2.
- Gamma period:
  - 1+GAMMA_LEN+UPDATE_LEN cycles with STDP_PHASE_EN.
  - 1+GAMMA_LEN cycles without it.
- gamma_rst spacing equals the gamma period exactly, with no idle gaps between consecutive gammas.
- Total run: num_gammas × period cycles of busy=1, followed by a 1-cycle done.
- A new start is accepted in the same cycle done is high; RST then follows next cycle.

## Configuration
- STDP_PHASE_EN defined: the UPDATE state and stdp_en are present, and UPDATE_LEN is used.
- STDP_PHASE_EN undefined:
  - No UPDATE state; COMPUTE exits directly to the end-of-gamma decision.
  - stdp_en is tied to 0.
  - UPDATE_LEN is ignored.
  - Gamma period is 1+GAMMA_LEN.

## Test plan
- Reset, then idle with start=0: all outputs 0 for 20 cycles. Assert rstn low mid-COMPUTE: all outputs 0 immediately.
- GAMMA_LEN=16, UPDATE_LEN=2, STDP_PHASE_EN, start with num_gammas=3:
  - gamma_rst pulses exactly 3 times, 19 cycles apart.
  - compute_en is high 16 cycles per gamma with time_step 0…15.
  - gamma_clk is high 9 cycles per gamma (RST plus 8).
  - stdp_en is high 2 cycles per gamma.
  - gamma_idx reads 0,1,2.
  - done pulses once, 57 cycles after the first gamma_rst.
- Same run without STDP_PHASE_EN: period 17 cycles, stdp_en never 1, done 51 cycles after the first gamma_rst.
- start with num_gammas=0: done=1 in the following cycle; busy, gamma_rst and compute_en stay 0.
- Assert abort at time_step=5 of gamma 1: all outputs 0 next cycle and no done. A subsequent start with num_gammas=1 runs normally from gamma_idx 0.
- Pulse start again while busy, and again in the done cycle:
  - The start while busy is ignored.
  - The start in the done cycle launches a new run with gamma_rst in the next cycle.
